spike_raster_fifo: RTL and testbench

SPIKE_RASTER_FIFO -- requirements
Module: spike_raster_fifo

---
 rtl/spike_raster_fifo.sv | 126 ++++++++++++
 tb/tb_spike_raster_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spike_raster_fifo.sv
// Spike raster FIFO: frame headers and neuron spike ids packed into one first-word-fall-through
// stream, with a one-entry holding register for spikes that collide with a header.
module spike_raster_fifo #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              spike,
  input  logic [15:0]       spkid,
  input  logic              frame_tick,
  input  logic              rd_en,
  output logic [15:0]       dout,
  output logic              dout_valid,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic [15:0]       drop_cnt
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LevelFull = {1'b1, {ADDR_W{1'b0}}};

  logic [15:0]       mem [Depth];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   level_q, level_d;
  logic [14:0]       frame_cnt_q, frame_cnt_d;
  logic              pend_valid_q, pend_valid_d;
  logic [14:0]       pend_word_q, pend_word_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  logic              pop;
  logic              wr_req, wr_acc, wr_en;
  logic [15:0]       wr_word;
  logic              spike_drop, full_drop;
  logic [16:0]       drop_sum;
  logic              unused_spkid_msb;

  assign unused_spkid_msb = spkid[15];

  always_comb begin
    pop          = rd_en && (level_q != '0);
    wr_req       = 1'b0;
    wr_word      = '0;
    frame_cnt_d  = frame_cnt_q;
    pend_valid_d = pend_valid_q;
    pend_word_d  = pend_word_q;
    spike_drop   = 1'b0;

    // One write slot per cycle: header, then held spike, then fresh spike.
    if (frame_tick) begin
      wr_req      = 1'b1;
      wr_word     = {1'b1, frame_cnt_q};
      frame_cnt_d = frame_cnt_q + 15'd1;
      if (spike) begin
        if (pend_valid_q) begin
          spike_drop = 1'b1;
        end else begin
          pend_valid_d = 1'b1;
          pend_word_d  = spkid[14:0];
        end
      end
    end else if (pend_valid_q) begin
      wr_req       = 1'b1;
      wr_word      = {1'b0, pend_word_q};
      pend_valid_d = 1'b0;
      spike_drop   = spike;
    end else if (spike) begin
      wr_req  = 1'b1;
      wr_word = {1'b0, spkid[14:0]};
    end

    // A pop in the same cycle frees a slot even when full.
    wr_acc    = wr_req && ((level_q != LevelFull) || pop);
    wr_en     = wr_acc && !clear;
    full_drop = wr_req && !wr_acc;

    level_d    = level_q + {{ADDR_W{1'b0}}, wr_acc} - {{ADDR_W{1'b0}}, pop};
    overflow_d = overflow_q | spike_drop | full_drop;
    drop_sum   = {1'b0, drop_cnt_q} + {16'd0, spike_drop} + {16'd0, full_drop};
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      frame_cnt_q  <= '0;
      pend_valid_q <= 1'b0;
      pend_word_q  <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
    end else if (clear) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      frame_cnt_q  <= '0;
      pend_valid_q <= 1'b0;
      pend_word_q  <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q      <= level_d;
      frame_cnt_q  <= frame_cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_word_q  <= pend_word_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Storage carries no reset so it can map onto RAM; stale words are masked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_word;
  end

  assign dout_valid = (level_q != '0);
  assign dout       = dout_valid ? mem[rd_ptr_q] : 16'h0000;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_spike_raster_fifo.sv
// Bench for spike_raster_fifo: directed scenarios plus random traffic against a queue model.
module tb_spike_raster_fifo;

  localparam int unsigned AW = 4;
  localparam int D = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        spike = 1'b0;
  logic [15:0] spkid = 16'h0;
  logic        frame_tick = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic [AW:0] level;
  logic        overflow;
  logic [15:0] drop_cnt;

  spike_raster_fifo #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .spike      (spike),
    .spkid      (spkid),
    .frame_tick (frame_tick),
    .rd_en      (rd_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .level      (level),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] q[$];
  bit          m_pend;
  logic [14:0] m_pend_id;
  int          m_frame;
  bit          m_ovf;
  int          m_drop;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_pend = 0;
    m_pend_id = '0;
    m_frame = 0;
    m_ovf = 0;
    m_drop = 0;
  endtask

  task automatic add_drop();
    m_ovf = 1;
    if (m_drop < 65535) m_drop++;
  endtask

  task automatic model_step(input bit s, input logic [15:0] id, input bit t, input bit r,
                            input bit c);
    bit          have;
    logic [15:0] w;
    int          size0;
    if (c) begin
      model_reset();
      return;
    end
    have = 0;
    w = '0;
    size0 = q.size();
    if (t) begin
      have = 1;
      w = {1'b1, 15'(m_frame)};
      m_frame = (m_frame + 1) % 32768;
      if (s) begin
        if (m_pend) add_drop();
        else begin
          m_pend = 1;
          m_pend_id = id[14:0];
        end
      end
    end else if (m_pend) begin
      have = 1;
      w = {1'b0, m_pend_id};
      m_pend = 0;
      if (s) add_drop();
    end else if (s) begin
      have = 1;
      w = {1'b0, id[14:0]};
    end
    if (r && size0 > 0) void'(q.pop_front());
    if (have) begin
      if (size0 == D && !(r && size0 > 0)) add_drop();
      else q.push_back(w);
    end
  endtask

  task automatic check_model();
    chk("level", 32'(level), 32'(q.size()));
    chk("dout_valid", 32'(dout_valid), 32'(q.size() > 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (q.size() > 0) chk("dout", 32'(dout), 32'(q[0]));
  endtask

  task automatic cyc(input bit s, input logic [15:0] id, input bit t, input bit r, input bit c);
    spike = s;
    spkid = id;
    frame_tick = t;
    rd_en = r;
    clear = c;
    @(posedge clk);
    model_step(s, id, t, r, c);
    #1;
    spike = 0;
    frame_tick = 0;
    rd_en = 0;
    clear = 0;
    check_model();
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    #10 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Header then spike two cycles later
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 16'h0005, 0, 0, 0);
    chk("req033_dout0", 32'(dout), 32'h8000);
    chk("req033_level", 32'(level), 2);
    chk("req033_ovf", 32'(overflow), 0);
    cyc(0, 0, 0, 1, 0);
    chk("req033_dout1", 32'(dout), 32'h0005);
    cyc(0, 0, 0, 1, 0);

    // Spike colliding with header, then a spike while the held one drains
    cyc(0, 0, 0, 0, 1);
    cyc(1, 16'h0012, 1, 0, 0);
    cyc(1, 16'h0013, 0, 0, 0);
    chk("req034_drop", 32'(drop_cnt), 1);
    chk("req034_ovf", 32'(overflow), 1);
    chk("req034_level", 32'(level), 2);
    chk("req034_dout0", 32'(dout), 32'h8000);
    cyc(0, 0, 0, 1, 0);
    chk("req034_dout1", 32'(dout), 32'h0012);
    cyc(0, 0, 0, 1, 0);
    chk("req034_empty", 32'(dout_valid), 0);

    // Overfill by two
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 18; i++) cyc(1, 16'h0100 + 16'(i), 0, 0, 0);
    chk("req035_level", 32'(level), 16);
    chk("req035_drop", 32'(drop_cnt), 2);
    for (int i = 0; i < 16; i++) begin
      chk("req035_order", 32'(dout), 32'h0100 + 32'(i));
      cyc(0, 0, 0, 1, 0);
    end
    chk("req035_empty", 32'(dout_valid), 0);

    // Full FIFO with simultaneous pop and write
    for (int i = 0; i < 16; i++) cyc(1, 16'h0200 + 16'(i), 0, 0, 0);
    cyc(1, 16'h02AA, 0, 1, 0);
    chk("req036_level", 32'(level), 16);
    chk("req036_drop", 32'(drop_cnt), 2);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 1, 0);
    chk("req036_last", 32'(dout), 32'h02AA);
    cyc(0, 0, 0, 1, 0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 2) == 0, 16'($urandom), $urandom_range(0, 4) == 0,
          $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
    end

    // Frame counter wrap
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 32769; i++) cyc(0, 0, 1, 1, 0);
    chk("req037_wrap", 32'(dout), 32'h8000);
    cyc(0, 0, 0, 0, 1);
    chk("req037_clr_level", 32'(level), 0);
    chk("req037_clr_ovf", 32'(overflow), 0);
    cyc(0, 0, 1, 0, 0);
    chk("req037_hdr", 32'(dout), 32'h8000);

    // Asynchronous reset with stored and held words
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 16'h0030 + 16'(i), 0, 0, 0);
    cyc(1, 16'h0077, 1, 0, 0);
    chk("req038_level5", 32'(level), 5);
    reset_n = 1'b0;
    #1;
    chk("req038_level", 32'(level), 0);
    chk("req038_valid", 32'(dout_valid), 0);
    chk("req038_dout", 32'(dout), 0);
    chk("req038_ovf", 32'(overflow), 0);
    chk("req038_drop", 32'(drop_cnt), 0);
    model_reset();
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_model();
    cyc(0, 0, 0, 0, 0);
    chk("req038_no_stale", 32'(dout_valid), 0);
    cyc(1, 16'h0042, 0, 0, 0);
    chk("req038_first_wr", 32'(dout), 32'h0042);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
